arith_req_arbiter: RTL and testbench
====================================

// Module: arith_req_arbiter
// PURPOSE
//  Shares one registered-output arithmetic unit (add/sub/mul/div, 1-cycle latency) between two requesters.
//  Round-robin arbitration, one operation in flight, valid/ready on both request and response sides.
//  Screens divide-by-zero locally and returns an error without issuing the operation to the unit.
// PARAMETERS
//  DATA_WIDTH  8  operand/result width; must match the arithmetic unit
// PORTS
//  clk          in   1           clock, all state on rising edge
//  rst_n        in   1           asynchronous, active-low reset
//  req0_valid   in   1           requester 0 command valid
//  req0_ready   out  1           requester 0 command accepted this cycle
//  req0_fun     in   2           00 add, 01 sub, 10 mul, 11 div
//  req0_a       in   DATA_WIDTH  operand 1
//  req0_b       in   DATA_WIDTH  operand 2
//  req1_*       --   --          same five signals as req0_*, for requester 1
//  rsp_valid    out  1           response valid
//  rsp_ready    in   1           response consumer ready
//  rsp_id       out  1           requester index owning the response
//  rsp_data     out  DATA_WIDTH  result (low DATA_WIDTH bits)
//  rsp_cout     out  1           carry/borrow/overflow bit from the unit
//  rsp_err      out  1           1 = div by zero or unit flag missing; rsp_data=0
//  alu_in1      out  DATA_WIDTH  to unit in1
//  alu_in2      out  DATA_WIDTH  to unit in2
//  alu_fun      out  2           to unit arith_fun
//  alu_en       out  1           to unit arith_en
//  alu_out      in   DATA_WIDTH  from unit arith_out (registered)
//  alu_cout     in   1           from unit arith_cout
//  alu_flag     in   1           from unit arith_flag
//  busy         out  1           1 in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, operand/result regs 0, last_grant=1 (req0 wins first tie).
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; IDLE -> RESP directly on div-by-zero.
//  IDLE: reqN_ready = reqN_valid & granted (combinational, only in IDLE; at most one ready high).
//   Grant: only one valid -> that one; both valid -> the one != last_grant. Handshake captures
//   fun/a/b/id into regs, updates last_grant. If fun==11 and b==0: result 0, err=1, go RESP.
//  ISSUE (1 cycle): alu_en=1, alu_fun/in1/in2 from regs. alu_en is 0 in every other state.
//  WAIT (1 cycle): unit output now valid; capture alu_out/alu_cout; err = ~alu_flag; go RESP.
//  RESP: rsp_valid=1, rsp_id/data/cout/err stable until rsp_valid & rsp_ready, then IDLE.
//   New request not accepted in the RESP handshake cycle; earliest next accept is cycle after.
//  alu_in1/in2/fun hold their last registered value outside ISSUE (unit ignores them with en=0).
//  Latency: accept edge -> rsp_valid high 3 cycles later (ISSUE, WAIT, RESP); div0: 1 cycle.
//  Throughput: max one op per 4 cycles with rsp_ready tied high.
//  Widths: no arithmetic in this block; result width/carry semantics are the unit's.
//  Request signals may change while reqN_ready=0; ignored until handshake. No queuing.
//  Reset asserted mid-operation: immediate abort to IDLE, in-flight result discarded, no response.
// TESTING
//  Single req0 add a=8'h F0 b=8'h20 -> rsp 3 cycles after accept: id=0 data=8'h10 cout=1 err=0.
//  req0 and req1 valid same cycle from reset -> req0 granted first, req1 next; alternates under load.
//  req1 div a=8'd7 b=0 -> alu_en never pulses; rsp next cycle id=1 data=0 err=1.
//  rsp_ready held 0 for 5 cycles on sub 3-5 -> rsp fields stable data=8'hFE cout=1; no req_ready.
//  rst_n low during WAIT of a mul -> all outputs 0 at once, no rsp_valid after release.
//  Back-to-back req0 mul 8'd16*8'd17 with rsp_ready=1 -> data=8'h10 cout=0; accepts every 4 cycles.

Source files
------------

// File: rtl/arith_req_arbiter.sv
// Two-requester round-robin front end for a shared 1-cycle registered arithmetic unit.
// One operation in flight; divide-by-zero is answered locally without touching the unit.
module arith_req_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [1:0]            req0_fun,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [1:0]            req1_fun,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_cout,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] alu_in1,
    output logic [DATA_WIDTH-1:0] alu_in2,
    output logic [1:0]            alu_fun,
    output logic                  alu_en,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_cout,
    input  logic                  alu_flag,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] FUN_DIV = 2'b11;

    state_t                r_state;
    logic                  r_last_grant;
    logic                  r_id;
    logic [1:0]            r_fun;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_alu_en;
    logic                  r_rsp_valid;
    logic                  r_rsp_id;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_cout;
    logic                  r_rsp_err;

    logic                  w_idle;
    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_accept;
    logic                  w_sel;
    logic [1:0]            w_fun;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic                  w_div0;

    // On a tie the requester that did not win last time is served.
    assign w_idle   = (r_state == S_IDLE);
    assign w_grant0 = req0_valid & (~req1_valid | r_last_grant);
    assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);

    assign req0_ready = w_idle & w_grant0;
    assign req1_ready = w_idle & w_grant1;

    assign w_accept = req0_ready | req1_ready;
    assign w_sel    = req1_ready;
    assign w_fun    = w_sel ? req1_fun : req0_fun;
    assign w_a      = w_sel ? req1_a   : req0_a;
    assign w_b      = w_sel ? req1_b   : req0_b;
    assign w_div0   = (w_fun == FUN_DIV) && (w_b == '0);

    // Operand registers drive the unit directly, so they hold between operations.
    assign alu_in1   = r_a;
    assign alu_in2   = r_b;
    assign alu_fun   = r_fun;
    assign alu_en    = r_alu_en;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_cout  = r_rsp_cout;
    assign rsp_err   = r_rsp_err;
    assign busy      = ~w_idle;

    // NOTE: every register, including the operand/result holding registers, is reset so a
    // mid-operation reset drives all outputs to zero at once and discards the in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_fun        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_alu_en     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_cout   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            // NOTE: default assignment first; alu_en is a single-cycle pulse issued only in ISSUE.
            r_alu_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_fun        <= w_fun;
                        r_a          <= w_a;
                        r_b          <= w_b;
                        r_id         <= w_sel;
                        r_last_grant <= w_sel;
                        if (w_div0) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_id    <= w_sel;
                            r_rsp_data  <= '0;
                            r_rsp_cout  <= 1'b0;
                            r_rsp_err   <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_alu_en <= 1'b1;
                            r_state  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A missing unit flag turns the result into an error with zero data.
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_id;
                    r_rsp_data  <= alu_flag ? alu_out : '0;
                    r_rsp_cout  <= alu_cout;
                    r_rsp_err   <= ~alu_flag;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_req_arbiter.sv
// Directed bench for arith_req_arbiter with a behavioural 1-cycle arithmetic unit attached.
// Inputs change 2 time units after each rising edge; outputs are sampled 1 unit later.
module tb_arith_req_arbiter;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          req0_valid;
    logic          req0_ready;
    logic [1:0]    req0_fun;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic          req1_valid;
    logic          req1_ready;
    logic [1:0]    req1_fun;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [DW-1:0] rsp_data;
    logic          rsp_cout;
    logic          rsp_err;
    logic [DW-1:0] alu_in1;
    logic [DW-1:0] alu_in2;
    logic [1:0]    alu_fun;
    logic          alu_en;
    logic [DW-1:0] alu_out;
    logic          alu_cout;
    logic          alu_flag;
    logic          busy;

    int vectors;
    int miscompares;
    int en_count;
    int en_snap;

    arith_req_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_fun   (req0_fun),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_fun   (req1_fun),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_cout   (rsp_cout),
        .rsp_err    (rsp_err),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_fun    (alu_fun),
        .alu_en     (alu_en),
        .alu_out    (alu_out),
        .alu_cout   (alu_cout),
        .alu_flag   (alu_flag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic unit: registered result one cycle after alu_en; carry only for add/sub.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out  <= '0;
            alu_cout <= 1'b0;
            alu_flag <= 1'b0;
        end else begin
            alu_flag <= alu_en;
            if (alu_en) begin
                case (alu_fun)
                    2'b00: {alu_cout, alu_out} <= {1'b0, alu_in1} + {1'b0, alu_in2};
                    2'b01: {alu_cout, alu_out} <= {1'b0, alu_in1} - {1'b0, alu_in2};
                    2'b10: begin
                        alu_out  <= DW'(alu_in1 * alu_in2);
                        alu_cout <= 1'b0;
                    end
                    default: begin
                        alu_out  <= (alu_in2 != '0) ? alu_in1 / alu_in2 : '0;
                        alu_cout <= 1'b0;
                    end
                endcase
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_count <= 0;
        else if (alu_en) en_count <= en_count + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of stimulus, required end before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic drive0(input logic v, input logic [1:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req0_valid = v;
        req0_fun   = f;
        req0_a     = a;
        req0_b     = b;
    endtask

    task automatic drive1(input logic v, input logic [1:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req1_valid = v;
        req1_fun   = f;
        req1_a     = a;
        req1_b     = b;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        rsp_ready   = 1'b0;
        drive0(1'b0, 2'b00, 8'h00, 8'h00);
        drive1(1'b0, 2'b00, 8'h00, 8'h00);

        // Reset state
        step();
        settle();
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_alu_en",    alu_en,    1'b0);
        check("rst_alu_in1",   alu_in1,   8'h00);
        check("rst_alu_in2",   alu_in2,   8'h00);
        check("rst_alu_fun",   alu_fun,   2'b00);
        check("rst_rsp_data",  rsp_data,  8'h00);
        check("rst_rsp_err",   rsp_err,   1'b0);
        rst_n = 1'b1;
        step();

        // Single req0 add F0+20
        rsp_ready = 1'b1;
        drive0(1'b1, 2'b00, 8'hF0, 8'h20);
        settle();
        check("add_req0_ready", req0_ready, 1'b1);
        check("add_req1_ready", req1_ready, 1'b0);
        step();
        drive0(1'b0, 2'b00, 8'h00, 8'h00);
        settle();
        check("add_issue_en",   alu_en,    1'b1);
        check("add_issue_in1",  alu_in1,   8'hF0);
        check("add_issue_in2",  alu_in2,   8'h20);
        check("add_issue_fun",  alu_fun,   2'b00);
        check("add_issue_busy", busy,      1'b1);
        check("add_issue_rspv", rsp_valid, 1'b0);
        step();
        settle();
        check("add_wait_en",    alu_en,    1'b0);
        check("add_wait_rspv",  rsp_valid, 1'b0);
        check("add_wait_in1",   alu_in1,   8'hF0);
        step();
        settle();
        check("add_rsp_valid",  rsp_valid, 1'b1);
        check("add_rsp_id",     rsp_id,    1'b0);
        check("add_rsp_data",   rsp_data,  8'h10);
        check("add_rsp_cout",   rsp_cout,  1'b1);
        check("add_rsp_err",    rsp_err,   1'b0);
        step();
        settle();
        check("add_done_rspv",  rsp_valid, 1'b0);
        check("add_done_busy",  busy,      1'b0);

        // Both valid from reset: req0 first, then req1, then req0 again
        apply_reset();
        drive0(1'b1, 2'b00, 8'd1, 8'd2);
        drive1(1'b1, 2'b01, 8'd9, 8'd4);
        settle();
        check("rr_first_r0", req0_ready, 1'b1);
        check("rr_first_r1", req1_ready, 1'b0);
        step();
        settle();
        check("rr_issue_r0", req0_ready, 1'b0);
        check("rr_issue_r1", req1_ready, 1'b0);
        step();
        step();
        settle();
        check("rr_rsp0_id",   rsp_id,   1'b0);
        check("rr_rsp0_data", rsp_data, 8'd3);
        step();
        settle();
        check("rr_second_r0", req0_ready, 1'b0);
        check("rr_second_r1", req1_ready, 1'b1);
        step();
        step();
        step();
        settle();
        check("rr_rsp1_valid", rsp_valid, 1'b1);
        check("rr_rsp1_id",    rsp_id,    1'b1);
        check("rr_rsp1_data",  rsp_data,  8'd5);
        check("rr_rsp1_cout",  rsp_cout,  1'b0);
        step();
        settle();
        check("rr_third_r0", req0_ready, 1'b1);
        check("rr_third_r1", req1_ready, 1'b0);
        drive0(1'b0, 2'b00, 8'h00, 8'h00);
        drive1(1'b0, 2'b00, 8'h00, 8'h00);
        settle();
        check("rr_idle_r0", req0_ready, 1'b0);

        // req1 divide by zero: answered next cycle, unit never enabled
        en_snap = en_count;
        drive1(1'b1, 2'b11, 8'd7, 8'd0);
        settle();
        check("div0_r1_ready", req1_ready, 1'b1);
        step();
        drive1(1'b0, 2'b00, 8'h00, 8'h00);
        settle();
        check("div0_rsp_valid", rsp_valid, 1'b1);
        check("div0_rsp_id",    rsp_id,    1'b1);
        check("div0_rsp_data",  rsp_data,  8'h00);
        check("div0_rsp_err",   rsp_err,   1'b1);
        check("div0_alu_en",    alu_en,    1'b0);
        check("div0_busy",      busy,      1'b1);
        step();
        settle();
        check("div0_done_rspv", rsp_valid, 1'b0);
        check("div0_en_pulses", en_count,  en_snap);

        // sub 3-5 with the consumer stalled for 5 cycles
        rsp_ready = 1'b0;
        drive0(1'b1, 2'b01, 8'd3, 8'd5);
        settle();
        check("stall_r0_ready", req0_ready, 1'b1);
        step();
        drive1(1'b1, 2'b00, 8'd1, 8'd1);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            settle();
            check("stall_rsp_valid", rsp_valid,  1'b1);
            check("stall_rsp_id",    rsp_id,     1'b0);
            check("stall_rsp_data",  rsp_data,   8'hFE);
            check("stall_rsp_cout",  rsp_cout,   1'b1);
            check("stall_rsp_err",   rsp_err,    1'b0);
            check("stall_r0_held",   req0_ready, 1'b0);
            check("stall_r1_held",   req1_ready, 1'b0);
            step();
        end
        rsp_ready = 1'b1;
        settle();
        check("stall_hs_rspv", rsp_valid,  1'b1);
        check("stall_hs_r0",   req0_ready, 1'b0);
        check("stall_hs_r1",   req1_ready, 1'b0);
        step();
        settle();
        check("stall_after_rspv", rsp_valid,  1'b0);
        check("stall_after_r0",   req0_ready, 1'b0);
        check("stall_after_r1",   req1_ready, 1'b1);
        drive0(1'b0, 2'b00, 8'h00, 8'h00);
        drive1(1'b0, 2'b00, 8'h00, 8'h00);

        // Reset during WAIT of a mul: everything clears, no response later
        drive0(1'b1, 2'b10, 8'd3, 8'd4);
        settle();
        check("abort_r0_ready", req0_ready, 1'b1);
        step();
        drive0(1'b0, 2'b00, 8'h00, 8'h00);
        step();
        settle();
        check("abort_wait_busy", busy, 1'b1);
        rst_n = 1'b0;
        settle();
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_busy",      busy,      1'b0);
        check("abort_alu_en",    alu_en,    1'b0);
        check("abort_alu_in1",   alu_in1,   8'h00);
        check("abort_alu_in2",   alu_in2,   8'h00);
        check("abort_alu_fun",   alu_fun,   2'b00);
        check("abort_rsp_data",  rsp_data,  8'h00);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            settle();
            check("abort_no_rsp", rsp_valid, 1'b0);
        end

        // Back-to-back req0 mul 16*17 with rsp_ready high: one accept every 4 cycles
        rsp_ready = 1'b1;
        drive0(1'b1, 2'b10, 8'd16, 8'd17);
        for (int cyc = 0; cyc < 12; cyc++) begin
            settle();
            check("b2b_r0_ready", req0_ready, ((cyc % 4) == 0) ? 1'b1 : 1'b0);
            check("b2b_rsp_valid", rsp_valid, ((cyc % 4) == 3) ? 1'b1 : 1'b0);
            if ((cyc % 4) == 3) begin
                check("b2b_rsp_data", rsp_data, 8'h10);
                check("b2b_rsp_cout", rsp_cout, 1'b0);
                check("b2b_rsp_err",  rsp_err,  1'b0);
            end
            step();
        end
        drive0(1'b0, 2'b00, 8'h00, 8'h00);
        settle();
        check("b2b_end_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
